// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Instruction/PC queue between fetch and decode. Circular buffer
//            with valid/ready handshakes on both sides and a single-cycle
//            flush that discards wrong-path instructions.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int              DATA_WIDTH = 32,
    parameter int              DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] NOP  = 32'h00000013
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        f_valid,
    input  logic [DATA_WIDTH-1:0]       f_instr,
    input  logic [DATA_WIDTH-1:0]       f_pc,
    input  logic [DATA_WIDTH-1:0]       f_pcplus4,
    output logic                        f_ready,
    output logic                        d_valid,
    output logic [DATA_WIDTH-1:0]       d_instr,
    output logic [DATA_WIDTH-1:0]       d_pc,
    output logic [DATA_WIDTH-1:0]       d_pcplus4,
    input  logic                        d_ready,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    // Entry storage; contents need no reset because count gates visibility.
    logic [DATA_WIDTH-1:0] mem_instr_q   [DEPTH];
    logic [DATA_WIDTH-1:0] mem_pc_q      [DEPTH];
    logic [DATA_WIDTH-1:0] mem_pcplus4_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic w_push;
    logic w_pop;

    // Handshake terms depend only on registered state and flush, so the
    // fetch trigger never sees a combinational path from d_ready.
    always_comb begin
        f_ready = (count_q != C_FULL) && !flush;
        d_valid = (count_q != '0);
        w_push  = f_valid && f_ready;
        w_pop   = d_valid && d_ready && !flush;
    end

    // Head presentation: NOP bubble with zero PCs when the queue is empty.
    always_comb begin
        d_instr   = NOP;
        d_pc      = '0;
        d_pcplus4 = '0;
        if (d_valid) begin
            d_instr   = mem_instr_q[rd_ptr_q];
            d_pc      = mem_pc_q[rd_ptr_q];
            d_pcplus4 = mem_pcplus4_q[rd_ptr_q];
        end
    end

    assign count = count_q;

    // Next-state for pointers and occupancy; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Write the accepted tuple into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_instr_q[wr_ptr_q]   <= f_instr;
            mem_pc_q[wr_ptr_q]      <= f_pc;
            mem_pcplus4_q[wr_ptr_q] <= f_pcplus4;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Directed self-checking bench for fetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DW = 32;
    localparam logic [31:0] C_NOP = 32'h00000013;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          f_valid;
    logic [DW-1:0] f_instr;
    logic [DW-1:0] f_pc;
    logic [DW-1:0] f_pcplus4;
    logic          f_ready;
    logic          d_valid;
    logic [DW-1:0] d_instr;
    logic [DW-1:0] d_pc;
    logic [DW-1:0] d_pcplus4;
    logic          d_ready;
    logic [2:0]    count;

    int n_checks;
    int n_fails;

    logic [31:0] fill_instr [4];

    fetch_queue #(
        .DATA_WIDTH (DW),
        .DEPTH      (4),
        .NOP        (C_NOP)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .f_valid   (f_valid),
        .f_instr   (f_instr),
        .f_pc      (f_pc),
        .f_pcplus4 (f_pcplus4),
        .f_ready   (f_ready),
        .d_valid   (d_valid),
        .d_instr   (d_instr),
        .d_pc      (d_pc),
        .d_pcplus4 (d_pcplus4),
        .d_ready   (d_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        f_valid   = v;
        f_pc      = pc;
        f_pcplus4 = pc + 32'd4;
        f_instr   = instr;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_dvalid"}, {31'd0, d_valid}, 32'd0);
        check({tag, "_dinstr"}, d_instr, C_NOP);
        check({tag, "_count"},  {29'd0, count}, 32'd0);
        check({tag, "_fready"}, {31'd0, f_ready}, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        fill_instr[0] = 32'h00500093;
        fill_instr[1] = 32'h00100113;
        fill_instr[2] = 32'h002081B3;
        fill_instr[3] = 32'hFE000EE3;

        rst = 1'b1; flush = 1'b0; d_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #2;
        check_empty("rst_active");
        check("rst_dpc", d_pc, 32'd0);
        check("rst_dpc4", d_pcplus4, 32'd0);
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_empty("idle");
        end

        // Fill to full with decode stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), fill_instr[i]);
            check("fill_fready", {31'd0, f_ready}, 32'd1);
            tick();
            check("fill_count", {29'd0, count}, 32'(i + 1));
            check("fill_head_pc", d_pc, 32'h0);
        end
        check("full_fready", {31'd0, f_ready}, 32'd0);
        drive(1'b1, 32'h10, 32'h00000000);
        tick();
        check("full_reject_count", {29'd0, count}, 32'd4);
        check("full_reject_fready", {31'd0, f_ready}, 32'd0);
        drive(1'b0, 32'h0, 32'h0);

        // Drain; a pop at full must not let f_ready rise in that cycle.
        d_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_dvalid", {31'd0, d_valid}, 32'd1);
            check("drain_pc", d_pc, 32'(4 * i));
            check("drain_pc4", d_pcplus4, 32'(4 * i + 4));
            check("drain_instr", d_instr, fill_instr[i]);
            if (i == 0) check("drain_full_fready", {31'd0, f_ready}, 32'd0);
            tick();
            check("drain_fready_after", {31'd0, f_ready}, 32'd1);
        end
        check_empty("drained");
        check("drained_dpc", d_pc, 32'd0);

        // Streaming with push and pop every cycle, crossing the pointer wrap.
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'(4 * k), 32'h10000000 + 32'(k));
            if (k == 0) begin
                check("stream_start_count", {29'd0, count}, 32'd0);
            end else begin
                check("stream_count", {29'd0, count}, 32'd1);
                check("stream_pc", d_pc, 32'(4 * (k - 1)));
                check("stream_instr", d_instr, 32'h10000000 + 32'(k - 1));
            end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0);
        check("stream_last_count", {29'd0, count}, 32'd1);
        check("stream_last_pc", d_pc, 32'h24);
        tick();
        check_empty("stream_end");

        // Flush concurrent with push and pop at count 3.
        d_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h30 + 32'(4 * i), 32'h20000000 + 32'(i));
            tick();
        end
        check("preflush_count", {29'd0, count}, 32'd3);
        check("preflush_head", d_pc, 32'h30);
        drive(1'b1, 32'h40, 32'h30000000);
        d_ready = 1'b1;
        flush   = 1'b1;
        #1;
        check("flush_fready_low", {31'd0, f_ready}, 32'd0);
        tick();
        flush   = 1'b0;
        d_ready = 1'b0;
        drive(1'b1, 32'h80, 32'h40000000);
        #1;
        check_empty("post_flush");
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("target_dvalid", {31'd0, d_valid}, 32'd1);
        check("target_pc", d_pc, 32'h80);
        check("target_pc4", d_pcplus4, 32'h84);
        check("target_instr", d_instr, 32'h40000000);
        check("target_count", {29'd0, count}, 32'd1);

        // Asynchronous reset while two entries are held.
        drive(1'b1, 32'h84, 32'h40000001);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("prerst_count", {29'd0, count}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_empty("async_rst");
        check("async_rst_dpc", d_pc, 32'd0);
        tick();
        #2;
        rst = 1'b0;
        tick();
        check_empty("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch stage (PC register, PC+4 adder, instruction memory) and the decode stage. It buffers up to DEPTH fetched instruction/PC tuples with a valid/ready handshake on both sides. Its f_ready output drives the fetch stage's PC advance trigger, so fetch stalls when the queue is full. A flush on taken branches or jumps discards all buffered, wrong-path instructions.

## Interface
- DATA_WIDTH, 32, width of instruction and PC fields
- DEPTH, 4, number of entries; power of two, at least 2
- NOP, 32'h00000013, instruction value presented on d_instr when the queue is empty (addi x0,x0,0)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  discard all entries; driven by PCSrc of the redirecting instruction
- f_valid  in  1  fetch presents a valid tuple
- f_instr  in  DATA_WIDTH  fetched instruction
- f_pc  in  DATA_WIDTH  PC of f_instr
- f_pcplus4  in  DATA_WIDTH  f_pc + 4
- f_ready  out  1  queue accepts a push this cycle; used as the fetch trigger
- d_valid  out  1  head entry valid
- d_instr  out  DATA_WIDTH  head instruction, or NOP when empty
- d_pc  out  DATA_WIDTH  head PC, or 0 when empty
- d_pcplus4  out  DATA_WIDTH  head PC+4, or 0 when empty
- d_ready  in  1  decode consumes the head this cycle
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: circular buffer of DEPTH entries. Each entry holds {instr, pc, pcplus4}. Pointers are wr_ptr and rd_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH. Occupancy is held in a separate count register.
- push = f_valid & f_ready & ~flush
- pop = d_valid & d_ready & ~flush
- f_ready = (count != DEPTH) & ~flush. f_ready depends on registered state and flush only. There is no combinational path from d_ready.
- d_valid = (count != 0). d_* outputs are read combinationally from the entry at rd_ptr. When count == 0, d_instr = NOP and d_pc = d_pcplus4 = 0.
- On push: write the entry at wr_ptr, then wr_ptr += 1.
- On pop: rd_ptr += 1.
- Count update: push only gives +1; pop only gives -1; push & pop gives no change; neither gives no change.
- Flush (synchronous, highest priority): wr_ptr, rd_ptr and count are set to 0. No push or pop occurs that cycle, and storage contents are don't-care.
- No fall-through: an instruction pushed in cycle N is visible on d_* no earlier than cycle N+1.
- Ordering is strict FIFO. Entries are never reordered or duplicated.
- f_valid is ignored when f_ready = 0. Fetch must hold its tuple, because its PC does not advance.

## Timing
- Reset (async assert, sync-safe deassert): wr_ptr = rd_ptr = count = 0. Outputs during and after reset: d_valid = 0, d_instr = NOP, d_pc = 0, d_pcplus4 = 0, f_ready = 1, count = 0.
- Push-to-head latency is 1 cycle when the queue is empty. Throughput is 1 push and 1 pop per cycle in steady state.
- Full (count == DEPTH): f_ready = 0. A pop in that cycle does not enable a push in the same cycle; f_ready rises the following cycle.
- Empty (count == 0): d_valid = 0. d_ready is ignored and count does not underflow.
- Simultaneous push and pop at count == 1: the old head is popped and the new entry becomes the head next cycle. count stays 1.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Data integrity holds across the wrap.
- Flush concurrent with f_valid or d_ready: flush wins. Next cycle count = 0, d_valid = 0, f_ready = 1.
- Reset asserted mid-operation: the queue empties immediately and asynchronously, with outputs at their reset values.

## Test plan
- Reset and idle: assert rst and release it, with f_valid = 0. Required: d_valid = 0, d_instr = 32'h00000013, count = 0, f_ready = 1 on every cycle.
- Fill to full: d_ready = 0; push PCs 0x0, 0x4, 0x8, 0xC with instructions 0x00500093, 0x00100113, 0x002081B3, 0xFE000EE3. Required: count reaches 4; f_ready = 0 on the cycle after the 4th push; a 5th f_valid tuple at PC 0x10 is not accepted.
- Drain in order from full: raise d_ready. Required: d_pc sequence is 0x0, 0x4, 0x8, 0xC on consecutive cycles with d_pcplus4 = d_pc + 4; then d_valid = 0 and d_instr = NOP.
- Streaming across wrap: f_valid = d_ready = 1 for 10 cycles, with PCs 0x0 to 0x24. Required: count stays 1 after the first cycle; d_pc lags f_pc by exactly 1 cycle; no entry is lost across the pointer wrap.
- Flush with push and pop: hold count = 3 and assert flush together with f_valid (PC 0x40) and d_ready. Required: next cycle count = 0, d_valid = 0, f_ready = 1. PC 0x40 is not enqueued. A push of target PC 0x80 on the following cycle appears at the head one cycle later.
- Async reset mid-stream: assert rst between clock edges while count = 2. Required: d_valid = 0 and count = 0 immediately, before the next clock edge.
